modbus_frame_tx: RTL and testbench

//  Frame-level Modbus RTU transmitter; sits directly upstream of the UART byte transmitter.

---
 rtl/modbus_pkg.sv | 29 ++
 rtl/modbus_frame_tx_if.sv | 25 ++
 rtl/crc16_modbus.sv | 59 +++++
 rtl/modbus_frame_tx.sv | 200 ++++++++++++++++++++
 tb/tb_modbus_frame_tx.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU frame transmitter: CRC constants, FSM states
// and helpers for bit timing and the reflected CRC16 shift.
package modbus_pkg;

    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // The high CRC byte is loaded on the WL exit edge, so it needs no state of its own.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LD   = 3'd2,
        ST_WT   = 3'd3,
        ST_CL   = 3'd4,
        ST_WL   = 3'd5,
        ST_WH   = 3'd6,
        ST_GAP  = 3'd7
    } tx_state_e;

    function automatic int unsigned bit_cyc(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic logic [15:0] crc16_shift(input logic [15:0] crc);
        return crc[0] ? ((crc >> 1) ^ CRC16_POLY) : (crc >> 1);
    endfunction

endpackage

// File: rtl/modbus_frame_tx_if.sv
// Frame request, TX buffer read port and byte-TX handshake of the Modbus frame transmitter.
interface modbus_frame_tx_if;

    logic       frame_start;
    logic [7:0] frame_len;
    logic [7:0] buf_rd_addr;
    logic [7:0] buf_rd_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    modport master (
        input  frame_start, frame_len, buf_rd_data, tx_done,
        output buf_rd_addr, tx_start, tx_data, busy, frame_done, frame_err
    );

    modport slave (
        output frame_start, frame_len, buf_rd_data, tx_done,
        input  buf_rd_addr, tx_start, tx_data, busy, frame_done, frame_err
    );

endinterface

// File: rtl/crc16_modbus.sv
// Bit-serial Modbus CRC16 (reflected poly 0xA001): one byte is folded in over 8 cycles,
// the first shift happening on the same edge that accepts the byte.
module crc16_modbus
    import modbus_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        init,
    input  logic        start,
    input  logic [7:0]  din,
    output logic [15:0] crc,
    output logic        busy
);

    logic [15:0] crc_d, crc_q;
    logic [2:0]  cnt_d, cnt_q;
    logic        busy_d, busy_q;

    // Next CRC value: init has priority, start folds the byte in, then 7 further shifts.
    always_comb begin
        crc_d  = crc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (init) begin
            crc_d  = CRC16_INIT;
            cnt_d  = 3'd0;
            busy_d = 1'b0;
        end else if (start) begin
            crc_d  = crc16_shift(crc_q ^ {8'h00, din});
            cnt_d  = 3'd7;
            busy_d = 1'b1;
        end else if (busy_q) begin
            crc_d  = crc16_shift(crc_q);
            cnt_d  = cnt_q - 3'd1;
            busy_d = (cnt_q != 3'd1);
        end else begin
            crc_d  = crc_q;
            cnt_d  = cnt_q;
            busy_d = 1'b0;
        end
    end

    // CRC state registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            crc_q  <= CRC16_INIT;
            cnt_q  <= 3'd0;
            busy_q <= 1'b0;
        end else begin
            crc_q  <= crc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign crc  = crc_q;
    assign busy = busy_q;

endmodule

// File: rtl/modbus_frame_tx.sv
// Modbus RTU frame transmitter: streams a payload from the TX buffer to the byte transmitter,
// appends the CRC16 low byte first, then holds the line silent for the inter-frame gap.
module modbus_frame_tx
    import modbus_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 32'd50000000,
    parameter int unsigned BAUD_RATE = 32'd9600,
    parameter int unsigned GAP_BITS  = 32'd39,
    parameter int unsigned TMO_BITS  = 32'd24
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    modbus_frame_tx_if.master bus
);

    localparam int unsigned BIT_CYC  = bit_cyc(CLK_FREQ, BAUD_RATE);
    localparam logic [23:0] TMO_LAST = 24'(TMO_BITS * BIT_CYC - 32'd1);
    localparam logic [23:0] GAP_LAST = 24'(GAP_BITS * BIT_CYC - 32'd1);

    tx_state_e   state_d, state_q;
    logic [7:0]  len_d, len_q;
    logic [7:0]  idx_d, idx_q;
    logic [7:0]  addr_d, addr_q;
    logic        tx_start_d, tx_start_q;
    logic [7:0]  tx_data_d, tx_data_q;
    logic        busy_d, busy_q;
    logic        done_d, done_q;
    logic        err_d, err_q;
    logic [23:0] cnt_d, cnt_q;

    logic        crc_init_s, crc_start_s, crc_busy_s;
    logic [15:0] crc_val_s;
    logic [7:0]  idx_inc_s;
    logic        more_s, tmo_s;
    logic [23:0] cnt_inc_s;

    crc16_modbus u_crc (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .init     (crc_init_s),
        .start    (crc_start_s),
        .din      (bus.buf_rd_data),
        .crc      (crc_val_s),
        .busy     (crc_busy_s)
    );

    // Nine-bit compare so that len 255 stops at idx 254 without wrapping.
    assign idx_inc_s = idx_q + 8'd1;
    assign more_s    = (({1'b0, idx_q} + 9'd1) < {1'b0, len_q});
    assign tmo_s     = (cnt_q >= TMO_LAST);
    assign cnt_inc_s = (cnt_q == 24'hFFFFFF) ? cnt_q : (cnt_q + 24'd1);

    // Frame sequencing, byte loading and watchdog/gap timing.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_d       = cnt_inc_s;
        crc_init_s  = 1'b0;
        crc_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 24'd0;
                if (bus.frame_start && (bus.frame_len != 8'd0)) begin
                    len_d      = bus.frame_len;
                    idx_d      = 8'd0;
                    addr_d     = 8'd0;
                    busy_d     = 1'b1;
                    crc_init_s = 1'b1;
                    state_d    = ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                state_d = ST_LD;
            end
            ST_LD: begin
                tx_data_d   = bus.buf_rd_data;
                tx_start_d  = 1'b1;
                crc_start_s = 1'b1;
                cnt_d       = 24'd0;
                state_d     = ST_WT;
            end
            ST_WT: begin
                if (bus.tx_done) begin
                    if (more_s) begin
                        idx_d   = idx_inc_s;
                        addr_d  = idx_inc_s;
                        state_d = ST_RD;
                    end else if (crc_busy_s) begin
                        state_d = ST_CL;
                    end else begin
                        tx_data_d  = crc_val_s[7:0];
                        tx_start_d = 1'b1;
                        cnt_d      = 24'd0;
                        state_d    = ST_WL;
                    end
                end else if (tmo_s) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WT;
                end
            end
            // Only reached if the last payload byte's CRC update is still running.
            ST_CL: begin
                if (!crc_busy_s) begin
                    tx_data_d  = crc_val_s[7:0];
                    tx_start_d = 1'b1;
                    cnt_d      = 24'd0;
                    state_d    = ST_WL;
                end else begin
                    state_d = ST_CL;
                end
            end
            ST_WL: begin
                if (bus.tx_done) begin
                    tx_data_d  = crc_val_s[15:8];
                    tx_start_d = 1'b1;
                    cnt_d      = 24'd0;
                    state_d    = ST_WH;
                end else if (tmo_s) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WL;
                end
            end
            ST_WH: begin
                if (bus.tx_done) begin
                    cnt_d   = 24'd1;
                    state_d = ST_GAP;
                end else if (tmo_s) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WH;
                end
            end
            ST_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            len_q      <= 8'd0;
            idx_q      <= 8'd0;
            addr_q     <= 8'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 24'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.buf_rd_addr = addr_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Directed bench for modbus_frame_tx: buffer RAM and byte-TX models, a vector table of
// frames with hand-computed CRCs, plus sequences for restart, stray tx_done, len 0/255 and reset.
module tb_modbus_frame_tx;

    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int BIT_CYC  = 16;
    localparam int GAP_LIM  = 39 * BIT_CYC;
    localparam int TMO_LIM  = 24 * BIT_CYC;
    localparam int BYTE_CYC = 40;

    typedef struct {
        logic [7:0]  len;
        logic [47:0] payload;
        logic [15:0] crc;
        int          suppress;
        bit          exp_err;
    } vec_t;

    logic clk_in;
    logic rst_n_in;
    modbus_frame_tx_if bus ();

    modbus_frame_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD),
        .GAP_BITS  (39),
        .TMO_BITS  (24)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [7:0] mem [256];
    always @(posedge clk_in) bus.buf_rd_data <= mem[bus.buf_rd_addr];

    logic model_done, stray_done;
    assign bus.tx_done = model_done | stray_done;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int nbytes, suppress_n, cur_len, stray_cd, wait_cnt;
    int first_start_cyc, last_start_cyc, last_done_cyc, done_cyc, err_cyc, fs_cyc;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int lat_err, stable_err;
    bit stray_en, pend, prev_start;
    logic [7:0] held;
    logic [7:0] wire_q [$];
    vec_t vecs [5];

    // Byte transmitter model and event monitor, all sampled on the falling edge.
    initial begin : byte_tx_model
        model_done = 1'b0;
        stray_done = 1'b0;
        pend = 1'b0;
        prev_start = 1'b0;
        stray_cd = 0;
        forever begin
            @(negedge clk_in);
            cyc = cyc + 1;
            model_done = 1'b0;
            stray_done = 1'b0;
            if (!rst_n_in) begin
                pend = 1'b0;
                prev_start = 1'b0;
                stray_cd = 0;
            end else begin
                if (stray_cd != 0) begin
                    stray_cd = stray_cd - 1;
                    if (stray_cd == 0) stray_done = 1'b1;
                end
                if (bus.frame_done) begin done_cnt++; done_cyc = cyc; end
                if (bus.frame_err) begin err_cnt++; err_cyc = cyc; end
                if (bus.frame_done && bus.frame_err) both_cnt++;
                if (pend) begin
                    if (bus.tx_data !== held) stable_err++;
                    if (wait_cnt == 0) begin
                        pend = 1'b0;
                        if (nbytes != suppress_n) begin
                            model_done = 1'b1;
                            last_done_cyc = cyc;
                            if (stray_en && nbytes < cur_len) stray_cd = 1;
                            else if (stray_en && nbytes == cur_len + 2) stray_cd = 5;
                        end
                    end else begin
                        wait_cnt = wait_cnt - 1;
                    end
                end
                if (bus.tx_start) begin
                    if (prev_start) lat_err++;
                    wire_q.push_back(bus.tx_data);
                    held = bus.tx_data;
                    pend = 1'b1;
                    wait_cnt = BYTE_CYC - 1;
                    nbytes++;
                    if (nbytes == 1) first_start_cyc = cyc;
                    else if ((cyc - last_done_cyc) != ((nbytes <= cur_len) ? 3 : 1)) lat_err++;
                    last_start_cyc = cyc;
                end
                prev_start = bus.tx_start;
            end
        end
    end

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input vec_t v, input int i);
        if (i < int'(v.len)) return v.payload[47 - 8 * i -: 8];
        else if (i == int'(v.len)) return v.crc[7:0];
        else return v.crc[15:8];
    endfunction

    task automatic prep(input int len, input int sup, input bit stray);
        wire_q.delete();
        nbytes = 0;
        lat_err = 0;
        stable_err = 0;
        suppress_n = sup;
        cur_len = len;
        stray_en = stray;
    endtask

    task automatic start_frame(input logic [7:0] len);
        bus.frame_len = len;
        bus.frame_start = 1'b1;
        fs_cyc = cyc;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_end(input int bd, input int be, input int restart_at, output bit tmo);
        tmo = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            bus.frame_start = (i == restart_at);
            if (i == restart_at) bus.frame_len = 8'd3;
            tick();
            bus.frame_start = 1'b0;
            if (done_cnt != bd || err_cnt != be) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int restart_at, input bit stray);
        int bd, be, nexp;
        bit tmo;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 6; i++) mem[i] = v.payload[47 - 8 * i -: 8];
        prep(int'(v.len), v.suppress, stray);
        bd = done_cnt;
        be = err_cnt;
        start_frame(v.len);
        wait_end(bd, be, restart_at, tmo);
        chk("frame_timeout", 32'(tmo), 32'd0);
        chk("frame_err_count", 32'(err_cnt - be), 32'(v.exp_err));
        chk("frame_done_count", 32'(done_cnt - bd), 32'(!v.exp_err));
        nexp = v.exp_err ? v.suppress : int'(v.len) + 2;
        chk("byte_count", 32'(wire_q.size()), 32'(nexp));
        for (int i = 0; i < nexp && i < wire_q.size(); i++)
            chk($sformatf("wire_byte%0d", i), 32'(wire_q[i]), 32'(exp_byte(v, i)));
        chk("first_tx_start_latency", 32'(first_start_cyc - fs_cyc), 32'd3);
        chk("inter_byte_latency_errors", 32'(lat_err), 32'd0);
        chk("tx_data_stability_errors", 32'(stable_err), 32'd0);
        if (v.exp_err) chk("watchdog_cycles", 32'(err_cyc - last_start_cyc), 32'(TMO_LIM));
        else chk("gap_cycles", 32'(done_cyc - last_done_cyc), 32'(GAP_LIM));
        chk("busy_after_frame", 32'(bus.busy), 32'd0);
        chk("done_and_err_together", 32'(both_cnt), 32'd0);
        if (v.exp_err) begin
            repeat (GAP_LIM + 50) tick();
            chk("no_done_after_err", 32'(done_cnt - bd), 32'd0);
            chk("no_tx_after_err", 32'(wire_q.size()), 32'(nexp));
        end
    endtask

    initial begin : main
        int bd, be, n0, mism;
        bit tmo, busy_seen;
        vecs[0] = '{8'd6, 48'h010300_00000A, 16'hCDC5, 0, 1'b0};
        vecs[1] = '{8'd6, 48'h010600_010003, 16'h0B98, 0, 1'b0};
        vecs[2] = '{8'd1, 48'hFF0000_000000, 16'h00FF, 0, 1'b0};
        vecs[3] = '{8'd2, 48'h010300_000000, 16'h2140, 0, 1'b0};
        vecs[4] = '{8'd6, 48'h010300_00000A, 16'hCDC5, 3, 1'b1};

        rst_n_in = 1'b0;
        bus.frame_start = 1'b0;
        bus.frame_len = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) tick();
        chk("reset_outputs", {23'd0, bus.tx_start, bus.busy, bus.frame_done, bus.frame_err,
            bus.tx_data[3:0], 1'b0}, 32'd0);
        chk("reset_addr_data", {16'd0, bus.buf_rd_addr, bus.tx_data}, 32'd0);
        rst_n_in = 1'b1;
        repeat (3) tick();

        for (int k = 0; k < 5; k++) run_vec(vecs[k], -1, 1'b0);

        // Restart request and stray tx_done while the frame is in flight.
        run_vec(vecs[1], 40, 1'b1);

        // Zero length request is dropped.
        prep(0, 0, 1'b0);
        n0 = nbytes;
        busy_seen = 1'b0;
        start_frame(8'd0);
        repeat (30) begin
            tick();
            if (bus.busy) busy_seen = 1'b1;
        end
        chk("len0_no_tx_start", 32'(nbytes), 32'(n0));
        chk("len0_busy", 32'(busy_seen), 32'd0);

        // Longest frame: idx must stop at 254 without wrapping.
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        prep(255, 0, 1'b0);
        bd = done_cnt;
        be = err_cnt;
        start_frame(8'd255);
        wait_end(bd, be, -1, tmo);
        chk("len255_timeout", 32'(tmo), 32'd0);
        chk("len255_byte_count", 32'(wire_q.size()), 32'd257);
        mism = 0;
        for (int i = 0; i < 255 && i < wire_q.size(); i++)
            if (wire_q[i] !== 8'(i)) mism++;
        chk("len255_payload_errors", 32'(mism), 32'd0);
        chk("len255_done", 32'(done_cnt - bd), 32'd1);

        // Reset in the middle of byte 4.
        for (int i = 0; i < 6; i++) mem[i] = vecs[0].payload[47 - 8 * i -: 8];
        prep(6, 0, 1'b0);
        start_frame(8'd6);
        for (int i = 0; i < 2000 && nbytes < 4; i++) tick();
        chk("reach_byte4", 32'(nbytes), 32'd4);
        repeat (5) tick();
        bd = done_cnt;
        be = err_cnt;
        rst_n_in = 1'b0;
        #1;
        chk("midreset_flags", {28'd0, bus.tx_start, bus.busy, bus.frame_done, bus.frame_err}, 32'd0);
        chk("midreset_addr_data", {16'd0, bus.buf_rd_addr, bus.tx_data}, 32'd0);
        tick();
        rst_n_in = 1'b1;
        repeat (3) tick();
        chk("midreset_no_pulse", 32'((done_cnt - bd) + (err_cnt - be)), 32'd0);
        run_vec(vecs[3], -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
